// File: rtl/rom_pipe_if.sv
// rom_pipe_if -- request/response bus of the pipelined ROM.
//
// Purpose: bundles the chip-select/output-enable controls, the request
// handshake (valid/ready + address) and the response handshake
// (valid/ready + error flag) into one port.
//
// Signals:
//   cs         chip select, active-low, gates request acceptance only
//   oe         output enable, active-high, gates the data pins only
//   req_valid  requester presents an address
//   req_ready  ROM accepts a request this cycle
//   addr       word address
//   rsp_valid  response (data/err) is being presented
//   rsp_ready  consumer takes the response this cycle
//   err        response address was outside the populated depth
//
// Modports: master = requester/consumer side, slave = ROM side.
// The read data pins are a tri-state bus and are a plain port of rom_pipe.
interface rom_pipe_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic                  cs;
    logic                  oe;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  err;

    modport master (
        output cs, oe, req_valid, addr, rsp_ready,
        input  req_ready, rsp_valid, err
    );

    modport slave (
        input  cs, oe, req_valid, addr, rsp_ready,
        output req_ready, rsp_valid, err
    );
endinterface

// File: rtl/rom_pipe.sv
// rom_pipe -- clocked read-only memory with valid/ready request and response
// handshakes and a 1..4 stage read pipeline.
//
// Purpose: instruction/constant store on the core fetch path. Sustains one
// read per cycle, stalls the whole pipeline under response backpressure and
// keeps the active-low CS / active-high OE behaviour of the async ROM it
// replaces.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active-low; empties the pipeline
//   bus    rom_pipe_if slave modport (cs, oe, request and response handshakes)
//   data   read data, high impedance whenever bus.oe = 0
//
// Parameters: DATA_WIDTH, ADDR_WIDTH, DEPTH (1..2**ADDR_WIDTH),
// LATENCY (1..4), INIT_FILE (image name; the content is a built-in pattern).
module rom_pipe #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 10,
    parameter int    DEPTH      = 1024,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = "rom_init.hex"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rom_pipe_if.slave             bus,
    output logic [DATA_WIDTH-1:0] data
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("rom_pipe: LATENCY=%0d is outside 1..4", LATENCY);
    end
    if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
        $error("rom_pipe: DEPTH=%0d is outside 1..2**ADDR_WIDTH", DEPTH);
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Image load at elaboration: the array is filled with an address-derived
    // pattern so the ROM is usable without an external image.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DATA_WIDTH'((32'(i) * 32'h0001_0001) ^ 32'hDEAD_BEEF);
        end
    end

    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [LATENCY-1:0]    err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];
    logic [DATA_WIDTH-1:0] dat_d [LATENCY];
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  stall;
    logic                  accept;
    logic                  in_oor;
    logic                  rd_oor;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;

    // One extra bit so DEPTH = 2**ADDR_WIDTH is representable (no wrap).
    assign in_oor = ({1'b0, bus.addr} >= (ADDR_WIDTH + 1)'(DEPTH));

    assign stall         = vld_q[LATENCY-1] & ~bus.rsp_ready;
    assign bus.req_ready = ~stall;
    assign accept        = bus.req_valid & ~stall & ~bus.cs;

    assign bus.rsp_valid = vld_q[LATENCY-1];
    assign bus.err       = err_q[LATENCY-1];
    assign data          = bus.oe ? dat_q[LATENCY-1] : {DATA_WIDTH{1'bz}};

    // With LATENCY=1 the array is read straight from the request so the
    // single register stage already holds data; otherwise stage 0 holds the
    // address and the read happens on the way into stage 1.
    always_comb begin
        rd_addr = (LATENCY == 1) ? bus.addr : addr_q;
        rd_oor  = (LATENCY == 1) ? in_oor   : err_q[0];
        rd_word = rd_oor ? '0 : mem[rd_addr];
    end

    // Whole-pipeline advance; bubbles move like data so ordering and timing
    // stay fixed. The error flag is only raised for accepted requests.
    always_comb begin
        vld_d  = vld_q;
        err_d  = err_q;
        addr_d = addr_q;
        for (int i = 0; i < LATENCY; i++) begin
            dat_d[i] = dat_q[i];
        end
        if (!stall) begin
            vld_d[0] = accept;
            err_d[0] = accept & in_oor;
            addr_d   = bus.addr;
            dat_d[0] = rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                err_d[i] = err_q[i-1];
                dat_d[i] = (i == 1) ? rd_word : dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            err_q  <= '0;
            addr_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            addr_q <= addr_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

endmodule
